// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end for one shared barrel shifter.
// Accepts one command at a time over per-requester valid/ready, evaluates it
// on the shifter, and returns the registered result with the owner index.
module shift_arbiter #(
  parameter int bit_size = 8,
  parameter int num_req  = 4,
  parameter int sw       = $clog2(bit_size),
  parameter int iw       = $clog2(num_req)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [num_req-1:0]         req_valid,
  output logic [num_req-1:0]         req_ready,
  input  logic [num_req*bit_size-1:0] req_data,
  input  logic [num_req*sw-1:0]      req_shift,
  input  logic [num_req-1:0]         req_dir,
  input  logic [2*num_req-1:0]       req_sel,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [iw-1:0]              rsp_id,
  output logic [bit_size-1:0]        rsp_out,
  output logic                       rsp_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [iw-1:0]             r_ptr;
  logic [iw-1:0]             r_id;
  logic [bit_size-1:0]       r_data;
  logic [sw-1:0]             r_shift;
  logic                      r_dir;
  logic [1:0]                r_sel;

  logic                      w_found;
  logic [iw-1:0]             w_gnt;
  int unsigned               w_idx;
  logic                      w_grant;
  logic [2*bit_size-1:0]     w_dbl_l;
  logic [2*bit_size-1:0]     w_dbl_r;
  logic [bit_size-1:0]       w_sra;
  logic [bit_size-1:0]       w_res;
  logic                      w_ov;

  // Priority search: first valid requester at or above ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int unsigned i = 0; i < num_req; i++) begin
      w_idx = (32'(r_ptr) + i) % num_req;
      if (!w_found && req_valid[iw'(w_idx)]) begin
        w_found = 1'b1;
        w_gnt   = iw'(w_idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and grant strobe; req_ready only ever high in IDLE out of reset.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst && w_found) begin
          w_grant          = 1'b1;
          req_ready[w_gnt] = 1'b1;
          w_state_nxt      = EXEC;
        end
      end
      EXEC:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shared shifter. Doubled operand gives rotates in one half and logical
  // shifts in the other; bit bit_size of the left copy is data[bit_size-n].
  always_comb begin
    w_dbl_l = {r_data, r_data} << r_shift;
    w_dbl_r = {r_data, r_data} >> r_shift;
    w_sra   = $signed(r_data) >>> r_shift;
    w_res   = '0;
    case (r_sel)
      2'd0:    w_res = r_dir ? w_dbl_r[2*bit_size-1:bit_size] : w_dbl_l[bit_size-1:0];
      2'd1:    w_res = r_dir ? w_sra : w_dbl_l[bit_size-1:0];
      2'd2:    w_res = r_dir ? w_dbl_r[bit_size-1:0] : w_dbl_l[2*bit_size-1:bit_size];
      default: w_res = '0;
    endcase
    w_ov = !r_sel[1] && !r_dir && (r_shift != '0) && w_dbl_l[bit_size];
  end

  // Command latch, result register and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_id         <= '0;
      r_data       <= '0;
      r_shift      <= '0;
      r_dir        <= 1'b0;
      r_sel        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_out      <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      if (w_grant) begin
        r_id    <= w_gnt;
        r_data  <= req_data[int'(w_gnt)*bit_size +: bit_size];
        r_shift <= req_shift[int'(w_gnt)*sw +: sw];
        r_dir   <= req_dir[w_gnt];
        r_sel   <= req_sel[int'(w_gnt)*2 +: 2];
      end
      if (r_state == EXEC) begin
        rsp_valid    <= 1'b1;
        rsp_id       <= r_id;
        rsp_out      <= w_res;
        rsp_overflow <= w_ov;
      end
      if (r_state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        if (r_id == iw'(num_req - 1)) r_ptr <= '0;
        else                          r_ptr <= r_id + 1'b1;
      end
    end
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin controller that shares one barrel-shift datapath (logical/arithmetic shift and rotate, left/right) among `num_req` requesters. Each requester issues a command through a valid/ready handshake. The block latches the granted command and evaluates it on the shared shifter. It then returns the registered result with the requester index over a single valid/ready response port. It sits between the ALU-side command sources and the shared shifter instance; one operation is in flight at a time.

## Interface
Parameters:
- `bit_size`, default 8: data width of each operand and result.
- `num_req`, default 4: number of requesters; must be ≥ 2.
- `sw`, derived = `$clog2(bit_size)`: shift-amount width.
- `iw`, derived = `$clog2(num_req)`: requester-index width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, `num_req`: per-requester command valid.
- `req_ready`, output, `num_req`: per-requester accept; at most one bit high per cycle.
- `req_data`, input, `num_req*bit_size`: operand; requester i occupies slice `[i*bit_size +: bit_size]`.
- `req_shift`, input, `num_req*sw`: shift amount, sliced the same way.
- `req_dir`, input, `num_req`: 0 = left, 1 = right.
- `req_sel`, input, `2*num_req`: 0 = logical, 1 = arithmetic, 2 = rotate, 3 = clear.
- `rsp_valid`, output, 1: result valid.
- `rsp_ready`, input, 1: consumer accepts the result.
- `rsp_id`, output, `iw`: index of the requester that owns the result.
- `rsp_out`, output, `bit_size`: shift result.
- `rsp_overflow`, output, 1: bit shifted out past the MSB on a left shift.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` bit is set, grant the first valid requester found by searching upward from priority pointer `ptr`, wrapping modulo `num_req`.
  - Assert `req_ready[g]` combinationally for the granted requester only.
  - Latch that requester's data, shift, dir, sel and index `g`, then go to EXEC.
  - With no valid requests, stay in IDLE with all `req_ready` low.
- EXEC:
  - Drive the latched command onto the shifter for one cycle.
  - Register `rsp_out` and `rsp_overflow`, then go to RESP.
- RESP:
  - Hold `rsp_valid` = 1 with `rsp_id`, `rsp_out` and `rsp_overflow` stable.
  - On `rsp_valid && rsp_ready`, set `ptr` = (g+1) mod `num_req` and go to IDLE.
- `req_ready` is all-zero in EXEC and RESP.
- Result rules, with n = shift amount and width `bit_size`:
  - sel 0: left is `data<<n` truncated; right is `data>>n` with zero fill.
  - sel 1: left is identical to sel 0; right sign-extends from `data` MSB.
  - sel 2: rotate by n in the given direction; n = 0 returns `data`.
  - sel 3: `rsp_out` = 0.
- Overflow rules:
  - `rsp_overflow` = `data[bit_size-n]` for a left shift with sel 0 or 1 and n > 0.
  - In every other case `rsp_overflow` = 0.
- `ptr` changes only on a completed response handshake.
- Reset values: `ptr` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_out` = 0, `rsp_overflow` = 0. `req_ready` is 0 during the reset cycle.

## Timing
- Request handshake in cycle T, i.e. `req_valid[g]` && `req_ready[g]` at edge T.
- Result registered at edge T+1; `rsp_valid` is high from cycle T+1 until the response handshake.
- With `rsp_ready` held high, the response handshake occurs at edge T+2 and a new grant is possible in the cycle after it. Peak throughput is one operation per 3 cycles.
- Requester inputs are sampled only at the grant edge; changes afterwards have no effect.
- Boundary conditions:
  - Simultaneous requests: exactly one is granted, per the `ptr` search. A requester that drops `req_valid` before being granted is never granted.
  - Backpressure: `rsp_ready` low holds RESP indefinitely with all response outputs frozen.
  - `rst` high in any state: at the next edge go to IDLE, clear `ptr`, drop `rsp_valid`, and discard the in-flight result. No `req_ready` is asserted in a cycle where `rst` is high.
  - `ptr` wraps from `num_req-1` to 0.

## Test plan
All scenarios use `bit_size` = 8 and `num_req` = 4.
- Req0 sends data 8'hB4, shift 1, dir 0, sel 0 -> `rsp_id` 0, `rsp_out` 8'h68, `rsp_overflow` 1, `rsp_valid` rising one cycle after the grant.
- Req2 sends 8'h90, shift 3, dir 1, sel 1 -> `rsp_out` 8'hF2, overflow 0. Req1 sends 8'h81, shift 1, dir 1, sel 2 -> 8'hC0. Req3 sends sel 3 -> 8'h00, overflow 0.
- All four `req_valid` held high, `rsp_ready` = 1, after reset -> grants in order 0, 1, 2, 3, 0, one every 3 cycles, `rsp_id` matching.
- `rsp_ready` = 0 for 5 cycles during RESP -> `rsp_valid`, `rsp_id` and `rsp_out` stay stable, all `req_ready` stay 0, and `ptr` does not advance.
- `rst` pulsed for one cycle while in EXEC -> next cycle in IDLE with `rsp_valid` 0 and no response for the aborted command. If req1 and req3 are valid, req1 is granted first because `ptr` = 0.
- Rotate left of 8'h01 by 0 and by 7 -> 8'h01 and 8'h80. Left logical of 8'hFF by 7 -> `rsp_out` 8'h80, overflow 1.
